mist32_memif_arbiter: RTL and testbench
=======================================

MIST32_MEMIF_ARBITER -- requirements
Module: mist32_memif_arbiter

Interface
REQ-001 SHALL have parameter P_CH, default 2: number of requester channels (2..8); channel 0 is the boot channel.
REQ-002 SHALL have parameter P_ADDR_W, default 32: memory word-address width.
REQ-003 SHALL have parameter P_WDATA_W, default 32: write-data width; mask width is P_WDATA_W/8.
REQ-004 SHALL have parameter P_RDATA_W, default 64: read-data width.
REQ-005 SHALL have parameter P_OUTSTANDING, default 4: maximum issued-but-unreturned reads (power of 2, >=2).
REQ-006 SHALL use one clock and an asynchronous active-high reset: iCLOCK in 1 (rising edge); iRESET in 1 (asynchronous, active-high); iRESET_SYNC in 1 (synchronous clear, active-high).
REQ-007 SHALL have iBOOT_MODE in 1: when 1, only channel 0 is eligible for grant.
REQ-008 SHALL have the channel-side ports iCH_REQ in P_CH, iCH_RW in P_CH (1 = write), iCH_MASK in P_CH*P_WDATA_W/8, iCH_ADDR in P_CH*P_ADDR_W, and iCH_DATA in P_CH*P_WDATA_W, all packed with channel i at slice i.
REQ-009 SHALL have oCH_LOCK out P_CH: 1 = channel must hold its request.
REQ-010 SHALL have oCH_VALID out P_CH (read data valid for channel i), iCH_BUSY in P_CH (channel i cannot take read data), and oCH_DATA out P_RDATA_W (read data, broadcast).
REQ-011 SHALL have the memory-request ports oMEMORY_REQ out 1, iMEMORY_BUSY in 1, oMEMORY_MASK out P_WDATA_W/8, oMEMORY_RW out 1, oMEMORY_ADDR out P_ADDR_W, and oMEMORY_DATA out P_WDATA_W.
REQ-012 SHALL have the memory-response ports iMEMORY_VALID in 1, oMEMORY_BUSY out 1, and iMEMORY_DATA in P_RDATA_W.
REQ-013 SHALL have oERR_UNEXPECTED out 1: sticky flag, read data returned with no read outstanding.

Function
REQ-014 SHALL treat channel i as eligible when iCH_REQ[i]=1 and (iBOOT_MODE=0 or i=0).
REQ-015 SHALL grant one eligible channel per cycle by round-robin, searching from (last_grant+1) mod P_CH upward.
REQ-016 SHALL define the output stage as free when oMEMORY_REQ=0 or iMEMORY_BUSY=0.
REQ-017 SHALL accept the granted channel g in a cycle when the stage is free and (iCH_RW[g]=1 or read_count < P_OUTSTANDING).
REQ-018 SHALL drive oCH_LOCK[g]=0 only in the accepting cycle; all other oCH_LOCK bits SHALL be 1 whenever the corresponding iCH_REQ=1, and 0 otherwise.
REQ-019 SHALL register the accepted request into the output stage (REQ, RW, MASK, ADDR, DATA) on that edge, giving 1-cycle latency from acceptance to oMEMORY_REQ.
REQ-020 SHALL hold the output stage unchanged while oMEMORY_REQ=1 and iMEMORY_BUSY=1.
REQ-021 SHALL clear oMEMORY_REQ when the stage drains (oMEMORY_REQ=1, iMEMORY_BUSY=0) and no new acceptance occurs in the same cycle.
REQ-022 SHALL update last_grant to g only on acceptance; a granted channel that is not accepted SHALL keep its priority.
REQ-023 SHALL push g into an order FIFO of depth P_OUTSTANDING on each read acceptance, and increment read_count.
REQ-024 SHALL, when the FIFO is non-empty with head h: oCH_VALID[h]=iMEMORY_VALID, oCH_DATA=iMEMORY_DATA, oMEMORY_BUSY=iCH_BUSY[h], and all other oCH_VALID bits 0.
REQ-025 SHALL pop the FIFO and decrement read_count when iMEMORY_VALID=1 and iCH_BUSY[h]=0.
REQ-026 SHALL, on simultaneous push and pop, leave read_count unchanged and update both pointers; the full check SHALL use read_count before the pop (no bypass).
REQ-027 SHALL, when the FIFO is empty: drive oMEMORY_BUSY=0 and all oCH_VALID bits 0, and drop iMEMORY_VALID=1 while setting oERR_UNEXPECTED=1 until reset.
REQ-028 SHALL wrap both FIFO pointers modulo P_OUTSTANDING.
REQ-029 SHALL, on a 0->1 change of iBOOT_MODE, let any in-flight output-stage request and outstanding reads complete normally.
REQ-030 SHALL drive oCH_DATA from iMEMORY_DATA combinationally; oCH_VALID and oMEMORY_BUSY SHALL likewise be combinational, with no added latency.

Reset
REQ-031 SHALL, on iRESET=1 (asynchronous) or iRESET_SYNC=1 (next edge), set oMEMORY_REQ, oMEMORY_RW, oMEMORY_MASK, oMEMORY_ADDR, oMEMORY_DATA, and oERR_UNEXPECTED to 0.
REQ-032 SHALL, on the same reset, set read_count and both FIFO pointers to 0 and last_grant to P_CH-1, so channel 0 wins first.
REQ-033 SHALL, on reset mid-operation, discard outstanding reads; subsequent iMEMORY_VALID SHALL be treated per REQ-027.

Verification
REQ-034 SHALL cover round-robin: P_CH=3 with all channels requesting reads, iMEMORY_BUSY=0 -> oMEMORY_REQ issued for ch0, ch1, ch2, ch0 on consecutive cycles starting 1 cycle after reset release.
REQ-035 SHALL cover boot mode: iBOOT_MODE=1 with ch0 and ch1 writing -> only ch0 accepted; oCH_LOCK[1]=1 throughout; ch1 accepted in the first cycle after iBOOT_MODE=0.
REQ-036 SHALL cover back-pressure: iMEMORY_BUSY=1 for 5 cycles with a stage holding ADDR=0x00001234 -> all output-stage fields stable for those 5 cycles, oCH_LOCK=1 for waiting channels, and the next request issued on the cycle after BUSY falls.
REQ-037 SHALL cover outstanding limit: P_OUTSTANDING=4, five reads, no returns -> fifth read locked; one iMEMORY_VALID return -> fifth read accepted in the same cycle as the pop-completing edge +1.
REQ-038 SHALL cover response routing: reads issued ch1, ch0, ch1 with returns D0=0xA, D1=0xB, D2=0xC -> oCH_VALID pulses [1],[0],[1] with matching data; iCH_BUSY[0]=1 for 2 cycles -> oMEMORY_BUSY=1 and D1 held 2 cycles.
REQ-039 SHALL cover unexpected data and reset: iMEMORY_VALID=1 with FIFO empty -> oERR_UNEXPECTED=1 and no oCH_VALID; iRESET asserted mid-burst -> all outputs 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/mist32_memif_arbiter_if.sv
// Bus bundle between requester channels, the arbiter and the memory port.
// master = arbiter side, slave = channels/memory side.
interface mist32_memif_arbiter_if #(
  parameter int unsigned P_CH      = 2,
  parameter int unsigned P_ADDR_W  = 32,
  parameter int unsigned P_WDATA_W = 32,
  parameter int unsigned P_RDATA_W = 64
);
  localparam int unsigned MASK_W = P_WDATA_W / 8;

  logic [P_CH-1:0]           iCH_REQ;
  logic [P_CH-1:0]           iCH_RW;
  logic [P_CH*MASK_W-1:0]    iCH_MASK;
  logic [P_CH*P_ADDR_W-1:0]  iCH_ADDR;
  logic [P_CH*P_WDATA_W-1:0] iCH_DATA;
  logic [P_CH-1:0]           oCH_LOCK;
  logic [P_CH-1:0]           oCH_VALID;
  logic [P_CH-1:0]           iCH_BUSY;
  logic [P_RDATA_W-1:0]      oCH_DATA;

  logic                      oMEMORY_REQ;
  logic                      iMEMORY_BUSY;
  logic [MASK_W-1:0]         oMEMORY_MASK;
  logic                      oMEMORY_RW;
  logic [P_ADDR_W-1:0]       oMEMORY_ADDR;
  logic [P_WDATA_W-1:0]      oMEMORY_DATA;
  logic                      iMEMORY_VALID;
  logic                      oMEMORY_BUSY;
  logic [P_RDATA_W-1:0]      iMEMORY_DATA;

  modport master (
    input  iCH_REQ, iCH_RW, iCH_MASK, iCH_ADDR, iCH_DATA, iCH_BUSY,
    input  iMEMORY_BUSY, iMEMORY_VALID, iMEMORY_DATA,
    output oCH_LOCK, oCH_VALID, oCH_DATA,
    output oMEMORY_REQ, oMEMORY_MASK, oMEMORY_RW, oMEMORY_ADDR, oMEMORY_DATA, oMEMORY_BUSY
  );

  modport slave (
    output iCH_REQ, iCH_RW, iCH_MASK, iCH_ADDR, iCH_DATA, iCH_BUSY,
    output iMEMORY_BUSY, iMEMORY_VALID, iMEMORY_DATA,
    input  oCH_LOCK, oCH_VALID, oCH_DATA,
    input  oMEMORY_REQ, oMEMORY_MASK, oMEMORY_RW, oMEMORY_ADDR, oMEMORY_DATA, oMEMORY_BUSY
  );
endinterface

// File: rtl/mist32_memif_arbiter.sv
// Round-robin arbiter of P_CH requesters onto one memory port, with an
// order FIFO that routes in-order read returns back to the issuing channel.
module mist32_memif_arbiter #(
  parameter int unsigned P_CH          = 2,
  parameter int unsigned P_ADDR_W      = 32,
  parameter int unsigned P_WDATA_W     = 32,
  parameter int unsigned P_RDATA_W     = 64,
  parameter int unsigned P_OUTSTANDING = 4
) (
  input  logic iCLOCK,
  input  logic iRESET,
  input  logic iRESET_SYNC,
  input  logic iBOOT_MODE,
  mist32_memif_arbiter_if.master bus,
  output logic oERR_UNEXPECTED
);

  localparam int unsigned CH_W   = $clog2(P_CH);
  localparam int unsigned MASK_W = P_WDATA_W / 8;
  localparam int unsigned PTR_W  = $clog2(P_OUTSTANDING);
  localparam int unsigned CNT_W  = PTR_W + 1;

  logic [CH_W-1:0]      r_last_grant;
  logic                 r_mem_req;
  logic                 r_mem_rw;
  logic [MASK_W-1:0]    r_mem_mask;
  logic [P_ADDR_W-1:0]  r_mem_addr;
  logic [P_WDATA_W-1:0] r_mem_data;
  logic                 r_err;
  logic [CH_W-1:0]      r_order [P_OUTSTANDING];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_read_count;

  logic [P_CH-1:0]      w_elig;
  logic [CH_W-1:0]      w_idx;
  logic [CH_W-1:0]      w_grant;
  logic                 w_grant_vld;
  logic                 w_grant_rw;
  logic                 w_stage_free;
  logic                 w_room;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic [CH_W-1:0]      w_head;

  // Boot mode masks every requester except channel 0.
  always_comb begin
    w_elig = bus.iCH_REQ;
    if (iBOOT_MODE) w_elig = bus.iCH_REQ & {{(P_CH-1){1'b0}}, 1'b1};
  end

  // Round-robin search starting just after the last accepted channel.
  always_comb begin
    w_grant     = '0;
    w_grant_vld = 1'b0;
    w_idx       = '0;
    for (int unsigned k = 1; k <= P_CH; k++) begin
      w_idx = CH_W'((32'(r_last_grant) + k) % P_CH);
      if (!w_grant_vld && w_elig[w_idx]) begin
        w_grant     = w_idx;
        w_grant_vld = 1'b1;
      end
    end
  end

  assign w_grant_rw   = bus.iCH_RW[w_grant];
  assign w_stage_free = ~r_mem_req | ~bus.iMEMORY_BUSY;
  // Room is judged on the pre-pop count; a same-cycle return does not free a slot.
  assign w_room       = r_read_count < CNT_W'(P_OUTSTANDING);
  assign w_accept     = w_grant_vld & w_stage_free & (w_grant_rw | w_room) & ~iRESET_SYNC;
  assign w_push       = w_accept & ~w_grant_rw;

  always_comb begin
    bus.oCH_LOCK = bus.iCH_REQ;
    if (w_accept) bus.oCH_LOCK[w_grant] = 1'b0;
  end

  assign w_empty = (r_read_count == '0);
  assign w_head  = r_order[r_rd_ptr];
  assign w_pop   = ~w_empty & bus.iMEMORY_VALID & ~bus.iCH_BUSY[w_head];

  // Read returns are steered to the oldest outstanding requester.
  always_comb begin
    bus.oCH_VALID    = '0;
    bus.oMEMORY_BUSY = 1'b0;
    if (!w_empty) begin
      bus.oCH_VALID[w_head] = bus.iMEMORY_VALID;
      bus.oMEMORY_BUSY      = bus.iCH_BUSY[w_head];
    end
  end

  assign bus.oCH_DATA     = bus.iMEMORY_DATA;
  assign bus.oMEMORY_REQ  = r_mem_req;
  assign bus.oMEMORY_RW   = r_mem_rw;
  assign bus.oMEMORY_MASK = r_mem_mask;
  assign bus.oMEMORY_ADDR = r_mem_addr;
  assign bus.oMEMORY_DATA = r_mem_data;
  assign oERR_UNEXPECTED  = r_err;

  // Output stage: load on accept, hold while memory is busy, drop REQ when drained.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_mem_req  <= 1'b0;
      r_mem_rw   <= 1'b0;
      r_mem_mask <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else if (iRESET_SYNC) begin
      r_mem_req  <= 1'b0;
      r_mem_rw   <= 1'b0;
      r_mem_mask <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else if (w_accept) begin
      r_mem_req  <= 1'b1;
      r_mem_rw   <= w_grant_rw;
      r_mem_mask <= bus.iCH_MASK[w_grant*MASK_W +: MASK_W];
      r_mem_addr <= bus.iCH_ADDR[w_grant*P_ADDR_W +: P_ADDR_W];
      r_mem_data <= bus.iCH_DATA[w_grant*P_WDATA_W +: P_WDATA_W];
    end else if (w_stage_free) begin
      r_mem_req  <= 1'b0;
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_last_grant <= CH_W'(P_CH - 1);
    end else if (iRESET_SYNC) begin
      r_last_grant <= CH_W'(P_CH - 1);
    end else if (w_accept) begin
      r_last_grant <= w_grant;
    end
  end

  // Order FIFO payload needs no reset; pointers and count define validity.
  always_ff @(posedge iCLOCK) begin
    if (w_push) r_order[r_wr_ptr] <= w_grant;
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_read_count <= '0;
    end else if (iRESET_SYNC) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_read_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_read_count <= r_read_count + CNT_W'(1);
        2'b01:   r_read_count <= r_read_count - CNT_W'(1);
        default: r_read_count <= r_read_count;
      endcase
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_err <= 1'b0;
    end else if (iRESET_SYNC) begin
      r_err <= 1'b0;
    end else if (w_empty && bus.iMEMORY_VALID) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mist32_memif_arbiter.sv
// Directed bench for mist32_memif_arbiter: vector table for round-robin,
// outstanding limit and routing, plus sequences for boot, back-pressure and reset.
module tb_mist32_memif_arbiter;
  localparam int unsigned CH = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned WW = 32;
  localparam int unsigned RW = 64;
  localparam int unsigned OS = 4;
  localparam int unsigned MW = WW / 8;

  logic clk = 1'b0;
  logic rst, rst_sync, boot, err;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mist32_memif_arbiter_if #(.P_CH(CH), .P_ADDR_W(AW), .P_WDATA_W(WW), .P_RDATA_W(RW)) bus ();

  mist32_memif_arbiter #(
    .P_CH(CH), .P_ADDR_W(AW), .P_WDATA_W(WW), .P_RDATA_W(RW), .P_OUTSTANDING(OS)
  ) dut (
    .iCLOCK(clk), .iRESET(rst), .iRESET_SYNC(rst_sync), .iBOOT_MODE(boot),
    .bus(bus), .oERR_UNEXPECTED(err)
  );

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  rw;
    logic        mvalid;
    logic [2:0]  exp_lock;
    logic [2:0]  exp_valid;
    logic        exp_mreq;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tv [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] mask);
    bus.iCH_ADDR[i*AW +: AW] = addr;
    bus.iCH_DATA[i*WW +: WW] = data;
    bus.iCH_MASK[i*MW +: MW] = mask;
  endtask

  task automatic sync_reset();
    rst_sync = 1'b1;
    cyc();
    rst_sync = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rst_sync = 1'b0; boot = 1'b0;
    bus.iCH_REQ = '0; bus.iCH_RW = '0; bus.iCH_BUSY = '0;
    bus.iMEMORY_BUSY = 1'b0; bus.iMEMORY_VALID = 1'b0; bus.iMEMORY_DATA = '0;
    for (int i = 0; i < 3; i++) set_ch(i, 32'h100 + 32'(i), 32'hD000 + 32'(i), 4'hF);

    //                req     rw      mv    lock    valid   mreq  addr
    tv[0]  = '{3'b111, 3'b000, 1'b0, 3'b110, 3'b000, 1'b1, 32'h100};
    tv[1]  = '{3'b111, 3'b000, 1'b0, 3'b101, 3'b000, 1'b1, 32'h101};
    tv[2]  = '{3'b111, 3'b000, 1'b0, 3'b011, 3'b000, 1'b1, 32'h102};
    tv[3]  = '{3'b111, 3'b000, 1'b0, 3'b110, 3'b000, 1'b1, 32'h100};
    tv[4]  = '{3'b111, 3'b000, 1'b0, 3'b111, 3'b000, 1'b0, 32'h0};
    tv[5]  = '{3'b111, 3'b000, 1'b1, 3'b111, 3'b001, 1'b0, 32'h0};
    tv[6]  = '{3'b111, 3'b000, 1'b0, 3'b101, 3'b000, 1'b1, 32'h101};
    tv[7]  = '{3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 32'h0};
    tv[8]  = '{3'b000, 3'b000, 1'b1, 3'b000, 3'b010, 1'b0, 32'h0};
    tv[9]  = '{3'b000, 3'b000, 1'b1, 3'b000, 3'b100, 1'b0, 32'h0};
    tv[10] = '{3'b000, 3'b000, 1'b1, 3'b000, 3'b001, 1'b0, 32'h0};
    tv[11] = '{3'b000, 3'b000, 1'b1, 3'b000, 3'b010, 1'b0, 32'h0};
    tv[12] = '{3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 32'h0};

    // Reset state
    #1;
    cyc(); cyc();
    chk("rst_mreq", 64'(bus.oMEMORY_REQ), 64'd0);
    chk("rst_addr", 64'(bus.oMEMORY_ADDR), 64'd0);
    chk("rst_mask", 64'(bus.oMEMORY_MASK), 64'd0);
    chk("rst_err",  64'(err), 64'd0);
    rst = 1'b0;

    // Round-robin, outstanding limit and in-order drain
    for (int i = 0; i < 13; i++) begin
      bus.iCH_REQ = tv[i].req;
      bus.iCH_RW = tv[i].rw;
      bus.iMEMORY_VALID = tv[i].mvalid;
      bus.iMEMORY_DATA = 64'(i) + 64'h50;
      #2;
      chk($sformatf("v%0d_lock", i), 64'(bus.oCH_LOCK), 64'(tv[i].exp_lock));
      chk($sformatf("v%0d_valid", i), 64'(bus.oCH_VALID), 64'(tv[i].exp_valid));
      if (tv[i].exp_valid != 3'b000)
        chk($sformatf("v%0d_data", i), bus.oCH_DATA, 64'(i) + 64'h50);
      cyc();
      chk($sformatf("v%0d_mreq", i), 64'(bus.oMEMORY_REQ), 64'(tv[i].exp_mreq));
      if (tv[i].exp_mreq)
        chk($sformatf("v%0d_addr", i), 64'(bus.oMEMORY_ADDR), 64'(tv[i].exp_addr));
    end
    bus.iMEMORY_VALID = 1'b0;
    chk("tbl_err_set", 64'(err), 64'd1);

    sync_reset();
    chk("sync_err_clr", 64'(err), 64'd0);
    chk("sync_mreq", 64'(bus.oMEMORY_REQ), 64'd0);

    // Boot mode: only channel 0 proceeds, channel 1 follows once released
    boot = 1'b1;
    bus.iCH_REQ = 3'b011; bus.iCH_RW = 3'b011;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("boot%0d_lock", i), 64'(bus.oCH_LOCK), 64'b010);
      cyc();
      chk($sformatf("boot%0d_addr", i), 64'(bus.oMEMORY_ADDR), 64'h100);
      chk($sformatf("boot%0d_rw", i), 64'(bus.oMEMORY_RW), 64'd1);
    end
    boot = 1'b0;
    #2;
    chk("boot_off_lock", 64'(bus.oCH_LOCK), 64'b001);
    cyc();
    chk("boot_off_addr", 64'(bus.oMEMORY_ADDR), 64'h101);
    bus.iCH_REQ = 3'b000;
    cyc();

    // Back-pressure: stage holds for 5 busy cycles, next issue right after
    sync_reset();
    set_ch(0, 32'h0000_1234, 32'hCAFE_0000, 4'h5);
    bus.iCH_REQ = 3'b001; bus.iCH_RW = 3'b001;
    cyc();
    chk("bp_load_addr", 64'(bus.oMEMORY_ADDR), 64'h1234);
    bus.iCH_REQ = 3'b010; bus.iCH_RW = 3'b010; bus.iMEMORY_BUSY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk($sformatf("bp%0d_lock", i), 64'(bus.oCH_LOCK), 64'b010);
      cyc();
      chk($sformatf("bp%0d_mreq", i), 64'(bus.oMEMORY_REQ), 64'd1);
      chk($sformatf("bp%0d_addr", i), 64'(bus.oMEMORY_ADDR), 64'h1234);
      chk($sformatf("bp%0d_data", i), 64'(bus.oMEMORY_DATA), 64'hCAFE_0000);
      chk($sformatf("bp%0d_mask", i), 64'(bus.oMEMORY_MASK), 64'h5);
      chk($sformatf("bp%0d_rw", i), 64'(bus.oMEMORY_RW), 64'd1);
    end
    bus.iMEMORY_BUSY = 1'b0;
    #2;
    chk("bp_rel_lock", 64'(bus.oCH_LOCK), 64'b000);
    cyc();
    chk("bp_rel_addr", 64'(bus.oMEMORY_ADDR), 64'h101);
    chk("bp_rel_mreq", 64'(bus.oMEMORY_REQ), 64'd1);
    bus.iCH_REQ = 3'b000;
    set_ch(0, 32'h100, 32'hD000, 4'hF);
    cyc();

    // Response routing: reads ch1, ch0, ch1; ch0 stalls its return 2 cycles
    sync_reset();
    bus.iCH_RW = 3'b000;
    bus.iCH_REQ = 3'b010; cyc();
    bus.iCH_REQ = 3'b001; cyc();
    bus.iCH_REQ = 3'b010; cyc();
    bus.iCH_REQ = 3'b000;
    bus.iMEMORY_VALID = 1'b1; bus.iMEMORY_DATA = 64'hA;
    #2;
    chk("rt_d0_valid", 64'(bus.oCH_VALID), 64'b010);
    chk("rt_d0_data", bus.oCH_DATA, 64'hA);
    chk("rt_d0_busy", 64'(bus.oMEMORY_BUSY), 64'd0);
    cyc();
    bus.iMEMORY_DATA = 64'hB; bus.iCH_BUSY = 3'b001;
    for (int i = 0; i < 2; i++) begin
      #2;
      chk($sformatf("rt_hold%0d_valid", i), 64'(bus.oCH_VALID), 64'b001);
      chk($sformatf("rt_hold%0d_busy", i), 64'(bus.oMEMORY_BUSY), 64'd1);
      chk($sformatf("rt_hold%0d_data", i), bus.oCH_DATA, 64'hB);
      cyc();
    end
    bus.iCH_BUSY = 3'b000;
    #2;
    chk("rt_d1_valid", 64'(bus.oCH_VALID), 64'b001);
    chk("rt_d1_busy", 64'(bus.oMEMORY_BUSY), 64'd0);
    cyc();
    bus.iMEMORY_DATA = 64'hC;
    #2;
    chk("rt_d2_valid", 64'(bus.oCH_VALID), 64'b010);
    chk("rt_d2_data", bus.oCH_DATA, 64'hC);
    cyc();
    chk("rt_no_err", 64'(err), 64'd0);

    // Unexpected return with nothing outstanding
    bus.iMEMORY_DATA = 64'hD; bus.iCH_BUSY = 3'b111;
    #2;
    chk("unx_valid", 64'(bus.oCH_VALID), 64'b000);
    chk("unx_busy", 64'(bus.oMEMORY_BUSY), 64'd0);
    cyc();
    chk("unx_err", 64'(err), 64'd1);
    bus.iMEMORY_VALID = 1'b0; bus.iCH_BUSY = 3'b000;

    // Asynchronous reset mid-burst clears everything without a clock edge
    bus.iCH_REQ = 3'b111;
    cyc(); cyc();
    chk("ar_pre_mreq", 64'(bus.oMEMORY_REQ), 64'd1);
    @(negedge clk);
    rst = 1'b1; bus.iMEMORY_VALID = 1'b1; bus.iCH_BUSY = 3'b111;
    #1;
    chk("ar_mreq", 64'(bus.oMEMORY_REQ), 64'd0);
    chk("ar_rw", 64'(bus.oMEMORY_RW), 64'd0);
    chk("ar_mask", 64'(bus.oMEMORY_MASK), 64'd0);
    chk("ar_addr", 64'(bus.oMEMORY_ADDR), 64'd0);
    chk("ar_data", 64'(bus.oMEMORY_DATA), 64'd0);
    chk("ar_err", 64'(err), 64'd0);
    chk("ar_valid", 64'(bus.oCH_VALID), 64'b000);
    chk("ar_busy", 64'(bus.oMEMORY_BUSY), 64'd0);
    bus.iCH_REQ = 3'b000;
    cyc();
    rst = 1'b0;
    cyc();
    chk("ar_post_err", 64'(err), 64'd1);
    chk("ar_post_valid", 64'(bus.oCH_VALID), 64'b000);
    bus.iMEMORY_VALID = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
